// File: rtl/hs_unit_debounce.sv
// Synchronizing debouncer: flop-chain sync, then a level is accepted
// only after DEBOUNCE_CYCLES consecutive differing samples.
//
// Ports:
//   clk         clock
//   aresetn     async active-low reset (sync release expected upstream)
//   signal_in   raw level, asynchronous to clk
//   glitch_clr  1-cycle pulse, clears glitch_flag
//   signal_out  debounced level, registered
//   busy        high while a candidate change is being qualified
//   glitch_flag sticky, set when a candidate change is rejected
module hs_unit_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic aresetn,
  input  logic signal_in,
  input  logic glitch_clr,
  output logic signal_out,
  output logic busy,
  output logic glitch_flag
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sig_sync;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], signal_in};
    end
  end

  assign sig_sync = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= STABLE;
      cnt         <= '0;
      signal_out  <= RESET_VALUE;
      glitch_flag <= 1'b0;
    end else begin
      // An abort below overrides this clear in the same cycle.
      if (glitch_clr) begin
        glitch_flag <= 1'b0;
      end
      unique case (state)
        STABLE: begin
          cnt <= '0;
          if (sig_sync != signal_out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              signal_out <= sig_sync;
            end else begin
              state <= CHECK;
              cnt   <= CNT_ONE;
            end
          end
        end
        CHECK: begin
          if (sig_sync == signal_out) begin
            state       <= STABLE;
            cnt         <= '0;
            glitch_flag <= 1'b1;
          end else if (cnt == CNT_MAX) begin
            state      <= STABLE;
            cnt        <= '0;
            signal_out <= sig_sync;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == CHECK);

endmodule

// File: tb/tb_hs_unit_debounce.sv
// Directed bench for hs_unit_debounce: DEBOUNCE_CYCLES=4 main build,
// plus RESET_VALUE=1 and DEBOUNCE_CYCLES=1 builds on shared inputs.
module tb_hs_unit_debounce;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic signal_in = 1'b0;
  logic glitch_clr = 1'b0;

  logic out_a, busy_a, glitch_a;
  logic out_r, busy_r, glitch_r;
  logic out_1, busy_1, glitch_1;

  int nvec = 0;
  int nfail = 0;
  int rises = 0;
  int busy1_hits = 0;
  logic prev_a = 1'b0;

  always #5 clk = ~clk;

  hs_unit_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b0)
  ) dut_a (
    .clk(clk), .aresetn(aresetn), .signal_in(signal_in),
    .glitch_clr(glitch_clr), .signal_out(out_a),
    .busy(busy_a), .glitch_flag(glitch_a)
  );

  hs_unit_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b1)
  ) dut_r (
    .clk(clk), .aresetn(aresetn), .signal_in(signal_in),
    .glitch_clr(glitch_clr), .signal_out(out_r),
    .busy(busy_r), .glitch_flag(glitch_r)
  );

  hs_unit_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(1'b0)
  ) dut_1 (
    .clk(clk), .aresetn(aresetn), .signal_in(signal_in),
    .glitch_clr(glitch_clr), .signal_out(out_1),
    .busy(busy_1), .glitch_flag(glitch_1)
  );

  // Downstream rising-edge detector model and busy watch on the 1-cycle build.
  always @(negedge clk) begin
    if (out_a && !prev_a) rises = rises + 1;
    prev_a = out_a;
    if (busy_1) busy1_hits = busy1_hits + 1;
  end

  typedef struct {
    bit in;
    bit clr;
    bit o;
    bit b;
    bit g;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit in, input bit clr,
                     input bit o, input bit b, input bit g);
    vec_t v;
    v.in = in; v.clr = clr; v.o = o; v.b = b; v.g = g;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic act, input logic exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s [%0d]: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      signal_in  = tbl[i].in;
      glitch_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      chk("out", i, out_a, tbl[i].o);
      chk("busy", i, busy_a, tbl[i].b);
      chk("glitch", i, glitch_a, tbl[i].g);
    end
  endtask

  task automatic tick(input bit in);
    @(negedge clk);
    signal_in  = in;
    glitch_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    // 2-cycle high pulse, abort, then glitch_clr
    add(1,0, 0,0,0); add(1,0, 0,0,0); add(0,0, 0,1,0);
    add(0,0, 0,1,0); add(0,0, 0,0,1); add(0,0, 0,0,1);
    add(0,1, 0,0,0); add(0,0, 0,0,0);
    // clean 0->1 step
    add(1,0, 0,0,0); add(1,0, 0,0,0); add(1,0, 0,1,0);
    add(1,0, 0,1,0); add(1,0, 0,1,0); add(1,0, 1,0,0);
    add(1,0, 1,0,0);
    // clean 1->0 step
    add(0,0, 1,0,0); add(0,0, 1,0,0); add(0,0, 1,1,0);
    add(0,0, 1,1,0); add(0,0, 1,1,0); add(0,0, 0,0,0);
    add(0,0, 0,0,0);
    // abort coinciding with glitch_clr: set wins
    add(1,0, 0,0,0); add(1,0, 0,0,0); add(0,0, 0,1,0);
    add(0,0, 0,1,0); add(0,1, 0,0,1); add(0,0, 0,0,1);
    add(0,1, 0,0,0);
    // bounces of width 1,2,3 then hold high
    add(1,0, 0,0,0); add(0,0, 0,0,0); add(1,0, 0,1,0);
    add(1,0, 0,0,1); add(0,0, 0,1,1); add(1,0, 0,1,1);
    add(1,0, 0,0,1); add(1,0, 0,1,1); add(0,0, 0,1,1);
    add(1,0, 0,1,1); add(1,0, 0,0,1); add(1,0, 0,1,1);
    add(1,0, 0,1,1); add(1,0, 0,1,1); add(1,0, 1,0,1);
    add(1,0, 1,0,1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 0, out_a, 1'b0);
    chk("rst_busy", 0, busy_a, 1'b0);
    chk("rst_glitch", 0, glitch_a, 1'b0);
    chk("rst_out_rv1", 0, out_r, 1'b1);
    @(negedge clk);
    aresetn = 1'b1;

    run_rows(0, 28);
    r0 = rises;
    run_rows(29, 44);
    nvec = nvec + 1;
    if (rises - r0 != 1) begin
      nfail = nfail + 1;
      $display("FAIL bounce_pulses: got %0d, want 1", rises - r0);
    end

    // async reset with a candidate mid-qualification (cnt=2)
    tick(0); tick(0); tick(0); tick(0);
    chk("pre_rst_busy", 0, busy_a, 1'b1);
    chk("pre_rst_out", 0, out_a, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_out", 0, out_a, 1'b0);
    chk("async_busy", 0, busy_a, 1'b0);
    chk("async_glitch", 0, glitch_a, 1'b0);
    chk("async_out_rv1", 0, out_r, 1'b1);
    @(negedge clk);
    aresetn   = 1'b1;
    signal_in = 1'b1;
    @(posedge clk); #1;
    tick(1);
    chk("req_busy_e2", 2, busy_a, 1'b0);
    chk("dc1_out_e2", 2, out_1, 1'b0);
    tick(1);
    chk("req_busy_e3", 3, busy_a, 1'b1);
    chk("dc1_out_e3", 3, out_1, 1'b1);
    tick(1);
    tick(1);
    chk("req_out_e5", 5, out_a, 1'b0);
    chk("req_busy_e5", 5, busy_a, 1'b1);
    tick(1);
    chk("req_out_e6", 6, out_a, 1'b1);
    chk("req_busy_e6", 6, busy_a, 1'b0);

    // 1-cycle build: never qualifies, so busy stays low throughout
    nvec = nvec + 1;
    if (busy1_hits != 0) begin
      nfail = nfail + 1;
      $display("FAIL dc1_busy: got %0d busy cycles, want 0", busy1_hits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
